interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Parametrised vectored interrupt controller between the CPU core and its interrupt sources (exception, I/O port, timer, syscall, and any added later). It latches requests per channel and applies a per-channel enable mask. It dispatches the highest-priority eligible request as a one-cycle pulse plus a subroutine address, and tracks in-service handlers on a nesting stack popped by the CPU's `s_finished` pulse. With `NEST_DEPTH=1` it behaves as a non-nesting controller; deeper stacks allow strictly-higher-priority preemption.

## Interface
- `N_SRC`, 4: number of interrupt channels. Channel 0 has the highest priority; priority decreases with index.
- `ADDR_W`, 10: width of the subroutine address.
- `NEST_DEPTH`, 1: maximum number of simultaneously in-service handlers (1..N_SRC).
- `VECTORS`, {10'h3FD,10'h012,10'h3FC,10'h3FB}: packed `N_SRC*ADDR_W` table. Slice `i` is the vector for channel `i`. Defaults: ch0 exception 0x3FB, ch1 port 0x3FC, ch2 timer 0x012, ch3 syscall 0x3FD.
- `EDGE_MODE`, {N_SRC{1'b1}}: per-channel bit. 1 = rising-edge triggered, 0 = level triggered.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `irq_in` in N_SRC: request lines, synchronous to `clk`.
- `enable` in N_SRC: per-channel enable. A masked channel may still latch requests but is never dispatched.
- `s_finished` in 1: one-cycle pulse from the CPU; the current handler has returned.
- `s_interruption` out 1: one-cycle dispatch pulse.
- `dir_out` out ADDR_W: vector of the top-of-stack handler; 0 when idle.
- `active` out 1: stack non-empty.
- `active_id` out max(1,$clog2(N_SRC)): channel at top of stack; 0 when idle.
- `pending` out N_SRC: latched request bits.

## Operation
- **Reset (`reset`=0, asynchronous):**
  - `s_interruption`, `dir_out`, `active`, `active_id` and `pending` all go to 0.
  - Stack becomes empty and the previous-`irq_in` history register is cleared.
  - Consequence: an edge channel held high through reset release latches one request on the first clock.
- **Latching:**
  - Edge channel `i`: `pending[i]` is set when `irq_in[i]`=1 and its history bit is 0.
  - Level channel `i`: `pending[i]` follows `irq_in[i]` every cycle, forced to 0 while `i` is anywhere on the stack.
- **Candidate:** the lowest index `c` with `pending[c] & enable[c]`.
- **Eligibility:** dispatch when all of the following hold:
  - a candidate exists;
  - `s_finished`=0 this cycle;
  - `s_interruption`=0 this cycle (one-cycle gap between dispatches);
  - the stack is empty, or depth < `NEST_DEPTH` and `c` < `active_id`.
- **Dispatch (single clock edge):**
  - push `c` onto the stack;
  - clear `pending[c]`, unless a new edge on `c` arrives in the same cycle, in which case the set wins;
  - `s_interruption`=1 for exactly one cycle;
  - `dir_out`=`VECTORS[c]`, `active_id`=`c`, `active`=1.
- **Return (`s_finished`=1 with stack non-empty):**
  - pop the stack;
  - `dir_out` and `active_id` switch to the new top, or to 0 / `active`=0 if the stack is now empty;
  - no dispatch in this cycle; eligibility is re-evaluated on the next cycle.
- **`s_finished` with empty stack:** ignored, with no state change.
- **Same channel already in service:** a new edge latches into `pending` and is dispatched only after that handler is popped. A channel never preempts itself or a higher-priority channel.
- **Enable changes:** take effect in the same cycle's candidate selection. Clearing `enable` never cancels an in-service handler.
- **Width rules:**
  - Stack storage is `NEST_DEPTH` entries of `active_id` width.
  - The depth counter is `$clog2(NEST_DEPTH+1)` bits.
  - `$clog2` is not used for 1-bit cases.

## Timing
- **Request latency:** `irq_in` rises before edge k → `pending` visible after edge k → `s_interruption` high during cycle k+1 (after edge k+1), provided the channel is eligible.
- **Output stability:** `dir_out` and `active_id` are valid from the same edge that raises `s_interruption`. They hold until the next push or pop.
- **Return-to-next-dispatch:**
  - `s_finished` sampled at edge m pops at edge m.
  - The earliest next `s_interruption` is after edge m+1.
- **Dispatch spacing:** two dispatches are at least 2 cycles apart.
- **Reset:** asynchronous assertion takes effect immediately, mid-dispatch or mid-handler. Release is synchronous to the first following rising edge.
- **Outputs:** all registered, with no combinational path from input to output.

## Test plan
- **Single-request latency:**
  - Stimulus: defaults; pulse `irq_in[2]` (timer) for 1 cycle with `enable`=4'hF.
  - Required: `s_interruption` high for exactly 1 cycle, 2 edges after the rise; `dir_out`=0x012 and `active_id`=2.
  - Then: `s_finished` → `active`=0 and `dir_out`=0.
- **Simultaneous requests:**
  - Stimulus: `irq_in`=4'b1111 for 1 cycle.
  - Required: dispatch order is 0x3FB, 0x3FC, 0x012, 0x3FD, each following one `s_finished`; `pending` walks 4'b1111 → 4'b1110 → 4'b1100 → 4'b1000 → 0.
- **Nesting (`NEST_DEPTH=2`):**
  - Stimulus: ch3 in service, then ch0 edge.
  - Required: ch0 preempts with `dir_out`=0x3FB. The first `s_finished` restores `dir_out`=0x3FD and `active_id`=3. A ch1 edge while depth=2 is held pending until a pop.
- **Mask and repeat request:**
  - Stimulus: `enable[1]`=0 with a ch1 edge, while ch2 is in service and a new ch2 edge arrives.
  - Required: no dispatch of ch1, with `pending[1]`=1. Setting `enable[1]`=1 after `s_finished` dispatches ch1 (0x3FC) before the re-latched ch2.
- **Level mode and reset:**
  - Stimulus: `EDGE_MODE[3]`=0 with `irq_in[3]` held high.
  - Required: redispatch after each `s_finished` + 1 cycle.
  - Then: assert `reset`=0 mid-handler → all outputs 0 immediately, without a clock.
- **Spurious finish:** `s_finished` pulsed while idle → no output change.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// ---------------------------------------------------------------------------
// interrupt_controller_if
// Bundles the request/dispatch signals between the interrupt sources, the
// CPU core and the interrupt controller.
//
//   irq_in         : per-channel request lines (sources -> controller)
//   enable         : per-channel dispatch enable (CPU -> controller)
//   s_finished     : one-cycle "handler returned" pulse (CPU -> controller)
//   s_interruption : one-cycle dispatch pulse (controller -> CPU)
//   dir_out        : subroutine address of the top-of-stack handler
//   active         : at least one handler in service
//   active_id      : channel at top of the in-service stack
//   pending        : latched request bits
//
// Modports: master = CPU/source side, slave = controller side.
// ---------------------------------------------------------------------------
interface interrupt_controller_if #(
    parameter int N_SRC  = 4,
    parameter int ADDR_W = 10,
    parameter int ID_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
    logic [N_SRC-1:0]  irq_in;
    logic [N_SRC-1:0]  enable;
    logic              s_finished;
    logic              s_interruption;
    logic [ADDR_W-1:0] dir_out;
    logic              active;
    logic [ID_W-1:0]   active_id;
    logic [N_SRC-1:0]  pending;

    modport master (
        output irq_in, enable, s_finished,
        input  s_interruption, dir_out, active, active_id, pending
    );

    modport slave (
        input  irq_in, enable, s_finished,
        output s_interruption, dir_out, active, active_id, pending
    );
endinterface

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Vectored, priority-ordered interrupt controller with an in-service nesting
// stack. Channel 0 has the highest priority. Requests are latched per channel
// (edge or level, per EDGE_MODE), masked by enable, and the best eligible one
// is dispatched as a one-cycle s_interruption pulse together with its vector.
// A deeper stack (NEST_DEPTH > 1) lets strictly higher-priority channels
// preempt the running handler; s_finished pops the stack.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : interrupt_controller_if.slave (see interface header)
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int                      N_SRC      = 4,
    parameter int                      ADDR_W     = 10,
    parameter int                      NEST_DEPTH = 1,
    parameter logic [N_SRC*ADDR_W-1:0] VECTORS    = {10'h3FD, 10'h012, 10'h3FC, 10'h3FB},
    parameter logic [N_SRC-1:0]        EDGE_MODE  = {N_SRC{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    interrupt_controller_if.slave    bus
);

    localparam int ID_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_irq_prev;
    logic [ID_W-1:0]    r_stack [NEST_DEPTH];
    logic [DEPTH_W-1:0] r_depth;
    logic               r_sint;
    logic [ADDR_W-1:0]  r_dir;
    logic               r_active;
    logic [ID_W-1:0]    r_active_id;

    logic [N_SRC-1:0]   w_edge;
    logic [N_SRC-1:0]   w_req;
    logic               w_has_cand;
    logic [ID_W-1:0]    w_cand;
    logic               w_room;
    logic               w_pop;
    logic               w_dispatch;
    logic               w_below_valid;
    logic [ID_W-1:0]    w_below_id;
    logic [N_SRC-1:0]   w_on_next;
    logic [N_SRC-1:0]   w_pend_next;

    function automatic logic [ADDR_W-1:0] vector_of(input logic [ID_W-1:0] id);
        return VECTORS[int'(id)*ADDR_W +: ADDR_W];
    endfunction

    assign w_edge = bus.irq_in & ~r_irq_prev;
    assign w_req  = r_pending & bus.enable;

    // Lowest-index eligible request wins (scan downwards, last hit is lowest).
    always_comb begin
        w_has_cand = 1'b0;
        w_cand     = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_has_cand = 1'b1;
                w_cand     = ID_W'(i);
            end
        end
    end

    assign w_room = int'(r_depth) < NEST_DEPTH;
    assign w_pop  = bus.s_finished && (r_depth != '0);

    // r_active_id always mirrors the top of the stack, so preemption compares
    // against it directly. s_finished and the gap after a dispatch both block.
    assign w_dispatch = w_has_cand && !bus.s_finished && !r_sint &&
                        ((r_depth == '0) || (w_room && (w_cand < r_active_id)));

    // Entry that becomes the new top after a pop (only exists for depth >= 2).
    always_comb begin
        w_below_valid = 1'b0;
        w_below_id    = '0;
        for (int k = 0; k < NEST_DEPTH - 1; k++) begin
            if (k + 2 == int'(r_depth)) begin
                w_below_valid = 1'b1;
                w_below_id    = r_stack[k];
            end
        end
    end

    // Stack membership after this edge; level channels are held off while in
    // service, so a popped level channel can re-latch on the popping edge.
    always_comb begin
        w_on_next = '0;
        for (int i = 0; i < N_SRC; i++) begin
            for (int k = 0; k < NEST_DEPTH; k++) begin
                if ((k < int'(r_depth)) && (int'(r_stack[k]) == i)) begin
                    w_on_next[i] = 1'b1;
                end
            end
            if (w_pop && (int'(r_active_id) == i)) begin
                w_on_next[i] = 1'b0;
            end
            if (w_dispatch && (int'(w_cand) == i)) begin
                w_on_next[i] = 1'b1;
            end
        end
    end

    // A fresh edge on the dispatched channel wins over its clear.
    always_comb begin
        w_pend_next = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (EDGE_MODE[i]) begin
                w_pend_next[i] = w_edge[i] |
                                 (r_pending[i] & ~(w_dispatch && (int'(w_cand) == i)));
            end else begin
                w_pend_next[i] = bus.irq_in[i] & ~w_on_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending   <= '0;
            r_irq_prev  <= '0;
            r_depth     <= '0;
            r_sint      <= 1'b0;
            r_dir       <= '0;
            r_active    <= 1'b0;
            r_active_id <= '0;
            for (int k = 0; k < NEST_DEPTH; k++) begin
                r_stack[k] <= '0;
            end
        end else begin
            r_irq_prev <= bus.irq_in;
            r_pending  <= w_pend_next;
            r_sint     <= w_dispatch;
            if (w_dispatch) begin
                for (int k = 0; k < NEST_DEPTH; k++) begin
                    if (k == int'(r_depth)) begin
                        r_stack[k] <= w_cand;
                    end
                end
                r_depth     <= r_depth + DEPTH_W'(1);
                r_dir       <= vector_of(w_cand);
                r_active_id <= w_cand;
                r_active    <= 1'b1;
            end else if (w_pop) begin
                r_depth <= r_depth - DEPTH_W'(1);
                if (w_below_valid) begin
                    r_dir       <= vector_of(w_below_id);
                    r_active_id <= w_below_id;
                end else begin
                    r_dir       <= '0;
                    r_active_id <= '0;
                    r_active    <= 1'b0;
                end
            end
        end
    end

    assign bus.s_interruption = r_sint;
    assign bus.dir_out        = r_dir;
    assign bus.active         = r_active;
    assign bus.active_id      = r_active_id;
    assign bus.pending        = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
// Two controllers share one stimulus stream: u_dut0 with default parameters
// (non-nesting, all edge channels) and u_dut1 with a 2-deep stack and
// channel 3 level-triggered. A behavioural model tracks both from the
// controller's rules; directed scenarios add fixed expected values.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    interrupt_controller_if #(.N_SRC(4), .ADDR_W(10)) bus0 ();
    interrupt_controller_if #(.N_SRC(4), .ADDR_W(10)) bus1 ();

    interrupt_controller #(
        .N_SRC(4), .ADDR_W(10), .NEST_DEPTH(1)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    interrupt_controller #(
        .N_SRC(4), .ADDR_W(10), .NEST_DEPTH(2), .EDGE_MODE(4'b0111)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_sint [2];
    logic [3:0] m_pend [2];
    logic [3:0] m_prev [2];
    int         m_stk  [2][4];
    int         m_dep  [2];

    function automatic logic [9:0] vec(input int c);
        case (c)
            0:       return 10'h3FB;
            1:       return 10'h3FC;
            2:       return 10'h012;
            default: return 10'h3FD;
        endcase
    endfunction

    function automatic logic is_edge(input int d, input int i);
        return (d == 0) ? 1'b1 : (i != 3);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sint[d] = 1'b0;
            m_pend[d] = 4'b0;
            m_prev[d] = 4'b0;
            m_dep[d]  = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] irq, input logic [3:0] en, input logic fin);
        for (int d = 0; d < 2; d++) begin
            int         cand;
            int         top;
            int         lim;
            logic       disp;
            logic       on;
            logic [3:0] np;
            cand = -1;
            for (int i = 3; i >= 0; i--)
                if (m_pend[d][i] && en[i]) cand = i;
            top = 0;
            if (m_dep[d] > 0) top = m_stk[d][m_dep[d] - 1];
            lim  = (d == 0) ? 1 : 2;
            disp = (cand >= 0) && !fin && !m_sint[d] &&
                   ((m_dep[d] == 0) || ((m_dep[d] < lim) && (cand < top)));
            if (fin && m_dep[d] > 0) m_dep[d]--;
            if (disp) begin
                m_stk[d][m_dep[d]] = cand;
                m_dep[d]++;
            end
            np = 4'b0;
            for (int i = 0; i < 4; i++) begin
                if (is_edge(d, i)) begin
                    if (irq[i] && !m_prev[d][i])  np[i] = 1'b1;
                    else if (disp && cand == i)   np[i] = 1'b0;
                    else                          np[i] = m_pend[d][i];
                end else begin
                    on = 1'b0;
                    for (int k = 0; k < m_dep[d]; k++)
                        if (m_stk[d][k] == i) on = 1'b1;
                    np[i] = irq[i] && !on;
                end
            end
            m_pend[d] = np;
            m_prev[d] = irq;
            m_sint[d] = disp;
        end
    endtask

    task automatic check_dut(input int d);
        logic       s, a;
        logic [9:0] dr, edir;
        logic [1:0] id, eid;
        logic [3:0] p;
        if (d == 0) begin
            s = bus0.s_interruption; dr = bus0.dir_out; a = bus0.active;
            id = bus0.active_id; p = bus0.pending;
        end else begin
            s = bus1.s_interruption; dr = bus1.dir_out; a = bus1.active;
            id = bus1.active_id; p = bus1.pending;
        end
        edir = 10'd0;
        eid  = 2'd0;
        if (m_dep[d] > 0) begin
            edir = vec(m_stk[d][m_dep[d] - 1]);
            eid  = 2'(m_stk[d][m_dep[d] - 1]);
        end
        chk($sformatf("d%0d_sint", d),   32'(s),  32'(m_sint[d]));
        chk($sformatf("d%0d_dir", d),    32'(dr), 32'(edir));
        chk($sformatf("d%0d_active", d), 32'(a),  32'(m_dep[d] > 0));
        chk($sformatf("d%0d_id", d),     32'(id), 32'(eid));
        chk($sformatf("d%0d_pend", d),   32'(p),  32'(m_pend[d]));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] irq, input logic [3:0] en, input logic fin);
        bus0.irq_in = irq;  bus1.irq_in = irq;
        bus0.enable = en;   bus1.enable = en;
        bus0.s_finished = fin;
        bus1.s_finished = fin;
    endtask

    // Inputs change just after a rising edge; outputs are sampled 1 ns after.
    task automatic cycle(input logic [3:0] irq, input logic [3:0] en, input logic fin);
        drive(irq, en, fin);
        @(posedge clk);
        model_step(irq, en, fin);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    // Asserts reset between edges and checks that outputs clear with no clock.
    task automatic do_reset(input logic [3:0] hold);
        drive(hold, 4'hF, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_sint0",  32'(bus0.s_interruption), 0);
        chk("rst_dir0",   32'(bus0.dir_out), 0);
        chk("rst_act0",   32'(bus0.active), 0);
        chk("rst_id0",    32'(bus0.active_id), 0);
        chk("rst_pend0",  32'(bus0.pending), 0);
        chk("rst_sint1",  32'(bus1.s_interruption), 0);
        chk("rst_dir1",   32'(bus1.dir_out), 0);
        chk("rst_act1",   32'(bus1.active), 0);
        chk("rst_pend1",  32'(bus1.pending), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [9:0] exp_dir  [4] = '{10'h3FB, 10'h3FC, 10'h012, 10'h3FD};
    logic [3:0] exp_pend [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        reset = 1'b1;
        drive(4'h0, 4'hF, 1'b0);
        model_reset();
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        reset = 1'b1;

        // Single request: timer pulse, dispatch two edges after the rise.
        cycle(4'b0100, 4'hF, 1'b0);
        chk("lat_pend", 32'(bus0.pending), 32'h4);
        chk("lat_sint_early", 32'(bus0.s_interruption), 0);
        cycle(4'b0000, 4'hF, 1'b0);
        chk("lat_sint", 32'(bus0.s_interruption), 1);
        chk("lat_dir", 32'(bus0.dir_out), 32'h012);
        chk("lat_id", 32'(bus0.active_id), 2);
        cycle(4'b0000, 4'hF, 1'b0);
        chk("lat_sint_once", 32'(bus0.s_interruption), 0);
        chk("lat_active", 32'(bus0.active), 1);
        cycle(4'b0000, 4'hF, 1'b1);
        chk("ret_active", 32'(bus0.active), 0);
        chk("ret_dir", 32'(bus0.dir_out), 0);

        // Simultaneous requests dispatched in priority order.
        cycle(4'b1111, 4'hF, 1'b0);
        chk("sim_pend0", 32'(bus0.pending), 32'hF);
        for (int j = 0; j < 4; j++) begin
            cycle(4'b0000, 4'hF, 1'b0);
            chk("sim_sint", 32'(bus0.s_interruption), 1);
            chk("sim_dir", 32'(bus0.dir_out), 32'(exp_dir[j]));
            chk("sim_pend", 32'(bus0.pending), 32'(exp_pend[j]));
            cycle(4'b0000, 4'hF, 1'b1);
        end

        // Nesting on the 2-deep controller.
        do_reset(4'b0000);
        cycle(4'b1000, 4'hF, 1'b0);
        cycle(4'b1000, 4'hF, 1'b0);
        chk("nest_ch3_dir", 32'(bus1.dir_out), 32'h3FD);
        cycle(4'b1001, 4'hF, 1'b0);
        cycle(4'b1000, 4'hF, 1'b0);
        chk("nest_pre_sint", 32'(bus1.s_interruption), 1);
        chk("nest_pre_dir", 32'(bus1.dir_out), 32'h3FB);
        chk("nest_pre_id", 32'(bus1.active_id), 0);
        cycle(4'b1010, 4'hF, 1'b0);
        cycle(4'b1000, 4'hF, 1'b0);
        chk("nest_full_sint", 32'(bus1.s_interruption), 0);
        chk("nest_full_p1", 32'(bus1.pending[1]), 1);
        cycle(4'b1000, 4'hF, 1'b1);
        chk("nest_pop_dir", 32'(bus1.dir_out), 32'h3FD);
        chk("nest_pop_id", 32'(bus1.active_id), 3);
        cycle(4'b1000, 4'hF, 1'b0);
        chk("nest_ch1_dir", 32'(bus1.dir_out), 32'h3FC);

        // Masked channel and repeat request of the in-service channel.
        do_reset(4'b0000);
        cycle(4'b0100, 4'hF, 1'b0);
        cycle(4'b0000, 4'hF, 1'b0);
        chk("mask_ch2_dir", 32'(bus0.dir_out), 32'h012);
        cycle(4'b0010, 4'b1101, 1'b0);
        cycle(4'b0100, 4'b1101, 1'b0);
        cycle(4'b0000, 4'b1101, 1'b0);
        chk("mask_no_sint", 32'(bus0.s_interruption), 0);
        chk("mask_p1", 32'(bus0.pending[1]), 1);
        chk("mask_p2", 32'(bus0.pending[2]), 1);
        cycle(4'b0000, 4'b1101, 1'b1);
        chk("mask_pop", 32'(bus0.active), 0);
        cycle(4'b0000, 4'hF, 1'b0);
        chk("mask_ch1_sint", 32'(bus0.s_interruption), 1);
        chk("mask_ch1_dir", 32'(bus0.dir_out), 32'h3FC);
        cycle(4'b0000, 4'hF, 1'b1);
        cycle(4'b0000, 4'hF, 1'b0);
        chk("mask_ch2_again", 32'(bus0.dir_out), 32'h012);
        cycle(4'b0000, 4'hF, 1'b1);

        // Level channel redispatches one cycle after each return.
        do_reset(4'b0000);
        cycle(4'b1000, 4'hF, 1'b0);
        cycle(4'b1000, 4'hF, 1'b0);
        chk("lvl_first", 32'(bus1.dir_out), 32'h3FD);
        for (int r = 0; r < 2; r++) begin
            cycle(4'b1000, 4'hF, 1'b0);
            cycle(4'b1000, 4'hF, 1'b1);
            chk("lvl_pop_sint", 32'(bus1.s_interruption), 0);
            cycle(4'b1000, 4'hF, 1'b0);
            chk("lvl_redisp", 32'(bus1.s_interruption), 1);
            chk("lvl_dir", 32'(bus1.dir_out), 32'h3FD);
        end
        chk("lvl_active", 32'(bus1.active), 1);
        do_reset(4'b0000);

        // Spurious finish while idle.
        cycle(4'b0000, 4'hF, 1'b1);
        chk("spur_active", 32'(bus0.active), 0);
        chk("spur_dir", 32'(bus0.dir_out), 0);
        chk("spur_sint", 32'(bus0.s_interruption), 0);

        // Edge channel held high through reset release latches once.
        do_reset(4'b0010);
        cycle(4'b0010, 4'hF, 1'b0);
        chk("hold_pend", 32'(bus0.pending), 32'h2);
        cycle(4'b0010, 4'hF, 1'b0);
        chk("hold_dir", 32'(bus0.dir_out), 32'h3FC);

        // Randomized traffic against the model.
        do_reset(4'b0000);
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] irq, en;
            logic       fin;
            irq = 4'($urandom) & 4'($urandom);
            en  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            fin = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) do_reset(4'($urandom));
            cycle(irq, en, fin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
